// File: rtl/motor_mode_sequencer.sv
// Line-follower motor mode sequencer: tracking, junction turns, lost/finish.
// Optional BRAKE_DWELL_EN inserts a STOP dwell before each turn.
module motor_mode_sequencer #(
  parameter int unsigned TURN_CYCLES  = 50000000,
  parameter int unsigned BACK_CYCLES  = 100000000,
  parameter int unsigned LOST_CYCLES  = 20000000,
  parameter int unsigned DWELL_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [2:0] sensor_i,
  input  logic       cmd_valid_i,
  input  logic [1:0] cmd_i,
  output logic       cmd_ready_o,
  output logic [4:0] mode_o,
  output logic [4:0] last_mode_o,
  output logic       busy_o
);

  localparam logic [4:0] M_IDLE     = 5'd0;
  localparam logic [4:0] M_STRAIGHT = 5'd3;
  localparam logic [4:0] M_LEFT     = 5'd5;
  localparam logic [4:0] M_RIGHT    = 5'd6;
  localparam logic [4:0] M_BACK     = 5'd7;
  localparam logic [4:0] M_LLEFT    = 5'd8;
  localparam logic [4:0] M_LRIGHT   = 5'd9;
  localparam logic [4:0] M_FINISH   = 5'd29;
  localparam logic [4:0] M_STOP     = 5'd30;
  localparam logic [4:0] M_ERROR    = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRACK,
`ifdef BRAKE_DWELL_EN
    S_DWELL,
`endif
    S_TURN,
    S_FINISHED,
    S_LOST
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  mode_q, mode_d;
  logic [4:0]  last_q;
  logic        busy_q, busy_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] lost_q, lost_d;

  function automatic logic [4:0] track_map(
    input logic [2:0] s,
    input logic [4:0] hold
  );
    logic [4:0] m;
    m = hold;
    unique case (s)
      3'b010, 3'b101, 3'b111: m = M_STRAIGHT;
      3'b100, 3'b110:         m = M_LLEFT;
      3'b001, 3'b011:         m = M_LRIGHT;
      default:                m = hold;
    endcase
    return m;
  endfunction

  function automatic logic [4:0] dir_of(input logic [1:0] c);
    logic [4:0] m;
    unique case (c)
      2'b00:   m = M_LEFT;
      2'b01:   m = M_RIGHT;
      default: m = M_BACK;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] len_of(input logic [4:0] d);
    return (d == M_BACK) ? BACK_CYCLES : TURN_CYCLES;
  endfunction

`ifdef BRAKE_DWELL_EN
  logic [4:0] dir_q, dir_d;
`else
  logic unused_dwell;
  assign unused_dwell = ^DWELL_CYCLES;
`endif

  assign cmd_ready_o = (state_q == S_TRACK) && en_i
                       && (sensor_i == 3'b111);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
`ifdef BRAKE_DWELL_EN
    dir_d   = dir_q;
`endif
    if (!en_i) begin
      state_d = S_IDLE;
      mode_d  = M_IDLE;
      cnt_d   = '0;
      lost_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_TRACK;
        S_TRACK: begin
          if (cmd_ready_o && cmd_valid_i) begin
            lost_d = '0;
            if (cmd_i == 2'b11) begin
              state_d = S_FINISHED;
              mode_d  = M_FINISH;
            end else begin
`ifdef BRAKE_DWELL_EN
              state_d = S_DWELL;
              mode_d  = M_STOP;
              dir_d   = dir_of(cmd_i);
              cnt_d   = DWELL_CYCLES;
`else
              state_d = S_TURN;
              mode_d  = dir_of(cmd_i);
              cnt_d   = len_of(dir_of(cmd_i));
`endif
            end
          end else if (sensor_i == 3'b000) begin
            // Saturate at the terminal count once the line is lost
            if (lost_q + 32'd1 >= LOST_CYCLES) begin
              state_d = S_LOST;
              mode_d  = M_ERROR;
              lost_d  = LOST_CYCLES;
            end else begin
              lost_d = lost_q + 32'd1;
            end
          end else begin
            lost_d = '0;
            mode_d = track_map(sensor_i, mode_q);
          end
        end
`ifdef BRAKE_DWELL_EN
        S_DWELL: begin
          if (cnt_q <= 32'd1) begin
            state_d = S_TURN;
            mode_d  = dir_q;
            cnt_d   = len_of(dir_q);
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
`endif
        S_TURN: begin
          if (cnt_q <= 32'd1) begin
            state_d = S_TRACK;
            cnt_d   = '0;
            mode_d  = track_map(sensor_i, mode_q);
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        default: ;
      endcase
    end
`ifdef BRAKE_DWELL_EN
    busy_d = (state_d == S_TURN) || (state_d == S_DWELL);
`else
    busy_d = (state_d == S_TURN);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_IDLE;
      last_q  <= M_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      lost_q  <= '0;
`ifdef BRAKE_DWELL_EN
      dir_q   <= M_IDLE;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      if (mode_d != mode_q) last_q <= mode_q;
`ifdef BRAKE_DWELL_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign mode_o      = mode_q;
  assign last_mode_o = last_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_motor_mode_sequencer.sv
// Scoreboard bench for motor_mode_sequencer against a phase-level model.
`timescale 1ns/1ps
module tb_motor_mode_sequencer;

  localparam int TC = 4;
  localparam int BC = 8;
  localparam int LC = 3;
  localparam int DC = 2;

  logic       clk = 0;
  logic       rst;
  logic       en;
  logic [2:0] sensor;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic [4:0] mode, last_mode;
  logic       busy;

  motor_mode_sequencer #(
    .TURN_CYCLES(TC), .BACK_CYCLES(BC),
    .LOST_CYCLES(LC), .DWELL_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en),
    .sensor_i(sensor), .cmd_valid_i(cmd_valid),
    .cmd_i(cmd), .cmd_ready_o(cmd_ready),
    .mode_o(mode), .last_mode_o(last_mode),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rdy;
    bit [4:0] mode;
    bit [4:0] last;
    bit       busy;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Model: a phase name plus remaining cycles in that phase.
  string ph;
  int    rem, lostn, m_mode, m_last, pend;

  function automatic int tmap(bit [2:0] s, int hold);
    int r;
    r = hold;
    if (s == 3'b010 || s == 3'b101 || s == 3'b111) r = 3;
    else if (s == 3'b100 || s == 3'b110) r = 8;
    else if (s == 3'b001 || s == 3'b011) r = 9;
    return r;
  endfunction

  task automatic model_reset();
    ph = "IDLE"; rem = 0; lostn = 0;
    m_mode = 0; m_last = 0; pend = 0;
  endtask

  task automatic cyc(bit e, bit [2:0] s, bit v, bit [1:0] c);
    exp_t x;
    int nm;
    @(posedge clk);
    #2;
    en = e; sensor = s; cmd_valid = v; cmd = c;
    x.rdy = (ph == "TRACK") && e && (s == 3'b111);
    nm = m_mode;
    if (!e) begin
      ph = "IDLE"; nm = 0; lostn = 0; rem = 0;
    end else if (ph == "IDLE") begin
      ph = "TRACK";
    end else if (ph == "TRACK") begin
      if (x.rdy && v) begin
        if (c == 3) begin
          ph = "FIN"; nm = 29;
        end else begin
          pend = (c == 0) ? 5 : (c == 1) ? 6 : 7;
`ifdef BRAKE_DWELL_EN
          ph = "DWELL"; rem = DC; nm = 30;
`else
          ph = "TURN"; nm = pend;
          rem = (pend == 7) ? BC : TC;
`endif
        end
      end else if (s == 0) begin
        lostn++;
        if (lostn >= LC) begin ph = "LOST"; nm = 31; end
      end else begin
        lostn = 0; nm = tmap(s, m_mode);
      end
    end else if (ph == "DWELL") begin
      rem--;
      if (rem == 0) begin
        ph = "TURN"; nm = pend;
        rem = (pend == 7) ? BC : TC;
      end
    end else if (ph == "TURN") begin
      rem--;
      if (rem == 0) begin
        ph = "TRACK"; lostn = 0; nm = tmap(s, m_mode);
      end
    end
    if (nm != m_mode) m_last = m_mode;
    m_mode = nm;
    x.mode = 5'(m_mode);
    x.last = 5'(m_last);
    x.busy = (ph == "TURN") || (ph == "DWELL");
    sbq.push_back(x);
  endtask

  initial begin : monitor
    exp_t r;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        r = sbq.pop_front();
        chk("cmd_ready", int'(cmd_ready), int'(r.rdy));
        @(posedge clk);
        #1;
        chk("mode", int'(mode), int'(r.mode));
        chk("last_mode", int'(last_mode), int'(r.last));
        chk("busy", int'(busy), int'(r.busy));
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit [2:0] s;
    int r;
    rst = 1; en = 0; sensor = 0; cmd_valid = 0; cmd = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode", int'(mode), 0);
    chk("rst_last", int'(last_mode), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    @(negedge clk);
    rst = 0;

    cyc(1, 3'b010, 0, 0);
    cyc(1, 3'b010, 0, 0);
    cyc(1, 3'b110, 0, 0);
    cyc(1, 3'b011, 0, 0);
    cyc(1, 3'b111, 1, 0);
    repeat (5) cyc(1, 3'b101, 0, 0);
    repeat (16) cyc(1, 3'b111, 1, 2);
    repeat (3) cyc(1, 3'b110, 0, 0);

    cyc(1, 3'b000, 0, 0);
    cyc(1, 3'b000, 0, 0);
    cyc(1, 3'b010, 0, 0);
    repeat (5) cyc(1, 3'b000, 0, 0);
    cyc(1, 3'b111, 1, 3);
    cyc(0, 3'b111, 0, 0);

    cyc(1, 3'b010, 0, 0);
    cyc(1, 3'b010, 0, 0);
    cyc(0, 3'b111, 1, 3);
    cyc(1, 3'b010, 0, 0);
    cyc(1, 3'b111, 1, 3);
    repeat (3) cyc(1, 3'b001, 1, 0);
    cyc(0, 3'b000, 0, 0);

    cyc(1, 3'b111, 0, 0);
    cyc(1, 3'b111, 1, 1);
    cyc(1, 3'b111, 0, 0);
    cyc(1, 3'b111, 0, 0);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("rst_mid_mode", int'(mode), 0);
    chk("rst_mid_last", int'(last_mode), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(cmd_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    en = 0;
    model_reset();
    cyc(0, 3'b111, 1, 0);
    cyc(1, 3'b111, 1, 0);
    cyc(1, 3'b111, 1, 0);

    repeat (400) begin
      r = $urandom_range(0, 9);
      s = (r < 3) ? 3'b111 : (r < 5) ? 3'b000 : 3'($urandom_range(0, 7));
      cyc($urandom_range(0, 19) != 0, s,
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    repeat (4) @(posedge clk);
    if (sbq.size() != 0) chk("drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
